// File: rtl/sccb_init_master_pkg.sv
// Shared definitions for the SCCB init sequencer: table opcodes, FSM
// encodings and default APB register map of the SCCB controller.
package sccb_init_master_pkg;

    // Table entry opcodes, entry[31:30]
    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_GPIO  = 2'b11;

    // Default register offsets of the SCCB controller
    localparam logic [31:0] DEF_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] DEF_CTRL_OFS = 32'h0000_0004;
    localparam logic [31:0] DEF_STAT_OFS = 32'h0000_0008;
    localparam logic [31:0] DEF_DIV_OFS  = 32'h0000_000C;
    localparam logic [31:0] DEF_GPIO_OFS = 32'h0000_0010;

    // Control word kicking off a 3-byte write: WR=3 in [7:4], Start in bit0
    localparam logic [31:0] CTRL_START_WR3 = 32'h0000_0031;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_FETCH, S_DECODE, S_WR_DATA, S_WR_CTRL,
        S_POLL, S_DELAY, S_GPIO, S_DONE, S_ERR
    } state_e;

    typedef enum logic [1:0] {
        A_IDLE, A_SETUP, A_ACCESS
    } apb_state_e;

    function automatic logic [1:0] entry_op(input logic [31:0] entry);
        return entry[31:30];
    endfunction

endpackage

// File: rtl/sccb_init_master_apb_mst.sv
// Single-transfer APB master. A request is accepted only while idle; the
// address/data/direction are latched so they stay stable for the whole
// transfer. ack pulses in the access cycle that sees pready.
module sccb_apb_mst
    import sccb_init_master_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    apb_state_e  st_q, st_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;

    // Transfer state and latched request; reset aborts any transfer at once
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            st_q    <= A_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // Idle -> setup -> access (held until pready) -> idle
    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (st_q)
            A_IDLE: begin
                if (req_i) begin
                    st_d    = A_SETUP;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wr_d    = wr_i;
                end
            end
            A_SETUP:  st_d = A_ACCESS;
            A_ACCESS: if (pready_i) st_d = A_IDLE;
            default:  st_d = A_IDLE;
        endcase
    end

    assign psel_o    = (st_q != A_IDLE);
    assign penable_o = (st_q == A_ACCESS);
    assign paddr_o   = addr_q;
    assign pwrite_o  = wr_q;
    assign pwdata_o  = wdata_q;
    assign ack_o     = (st_q == A_ACCESS) && pready_i;
    assign err_o     = ack_o && pslverr_i;
    assign rdata_o   = prdata_i;

endmodule

// File: rtl/sccb_init_master.sv
// Table-driven SCCB init sequencer. Walks a ROM of 32-bit entries and turns
// each into APB accesses on an SCCB controller: register writes with busy
// polling, fixed delays and a GPIO level. Stops on END, bus error, poll
// timeout or running off the end of the table.
module sccb_init_master
    import sccb_init_master_pkg::*;
#(
    parameter logic [31:0] DATA_OFS = DEF_DATA_OFS,
    parameter logic [31:0] CTRL_OFS = DEF_CTRL_OFS,
    parameter logic [31:0] STAT_OFS = DEF_STAT_OFS,
    parameter logic [31:0] DIV_OFS  = DEF_DIV_OFS,
    parameter logic [31:0] GPIO_OFS = DEF_GPIO_OFS,
    parameter logic [7:0]  DEV_ID   = 8'h78,
    parameter logic [31:0] DIV_WORD = 32'h0032_0064,
    parameter int          TBL_AW   = 8,
    parameter logic [15:0] POLL_TO  = 16'd50000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic [31:0]       M_APB_paddr,
    output logic              M_APB_psel,
    output logic              M_APB_penable,
    output logic              M_APB_pwrite,
    output logic [31:0]       M_APB_pwdata,
    input  logic [31:0]       M_APB_prdata,
    input  logic              M_APB_pready,
    input  logic              M_APB_pslverr
);

    localparam logic [TBL_AW-1:0] LAST_IDX = {TBL_AW{1'b1}};

    state_e             state_q, state_d;
    logic [TBL_AW-1:0]  idx_q, idx_d;
    logic [23:0]        entry_q, entry_d;
    logic [23:0]        dly_q, dly_d;
    logic [15:0]        poll_q, poll_d;
    logic               error_q, error_d;
    logic [TBL_AW-1:0]  eidx_q, eidx_d;

    logic        apb_req, apb_wr, apb_ack, apb_err;
    logic [31:0] apb_addr, apb_wdata, apb_rdata;
    logic        adv;

    // Opcode bits above the payload and status bits above Busy are don't-care
    logic unused_bits;
    assign unused_bits = ^{tbl_data[29:24], apb_rdata[31:1]};

    sccb_apb_mst u_apb (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (apb_req),
        .wr_i      (apb_wr),
        .addr_i    (apb_addr),
        .wdata_i   (apb_wdata),
        .ack_o     (apb_ack),
        .rdata_o   (apb_rdata),
        .err_o     (apb_err),
        .paddr_o   (M_APB_paddr),
        .psel_o    (M_APB_psel),
        .penable_o (M_APB_penable),
        .pwrite_o  (M_APB_pwrite),
        .pwdata_o  (M_APB_pwdata),
        .prdata_i  (M_APB_prdata),
        .pready_i  (M_APB_pready),
        .pslverr_i (M_APB_pslverr)
    );

    // Sequencer state, table index, counters and sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            entry_q <= '0;
            dly_q   <= '0;
            poll_q  <= '0;
            error_q <= 1'b0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            entry_q <= entry_d;
            dly_q   <= dly_d;
            poll_q  <= poll_d;
            error_q <= error_d;
            eidx_q  <= eidx_d;
        end
    end

    // Next state and APB request generation; adv = current entry finished
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        entry_d   = entry_q;
        dly_d     = dly_q;
        poll_d    = poll_q;
        error_d   = error_q;
        eidx_d    = eidx_q;
        apb_req   = 1'b0;
        apb_wr    = 1'b1;
        apb_addr  = '0;
        apb_wdata = '0;
        adv       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                apb_req   = 1'b1;
                apb_addr  = DIV_OFS;
                apb_wdata = DIV_WORD;
                if (apb_ack) state_d = apb_err ? S_ERR : S_FETCH;
            end
            // tbl_addr is stable here; the ROM answers next cycle
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                entry_d = tbl_data[23:0];
                case (entry_op(tbl_data))
                    OP_END:   state_d = S_DONE;
                    OP_WRITE: state_d = S_WR_DATA;
                    OP_GPIO:  state_d = S_GPIO;
                    default: begin
                        dly_d = tbl_data[23:0];
                        if (tbl_data[23:0] == 24'd0) adv = 1'b1;
                        else                         state_d = S_DELAY;
                    end
                endcase
            end
            S_WR_DATA: begin
                apb_req   = 1'b1;
                apb_addr  = DATA_OFS;
                apb_wdata = {DEV_ID, entry_q};
                if (apb_ack) state_d = apb_err ? S_ERR : S_WR_CTRL;
            end
            S_WR_CTRL: begin
                apb_req   = 1'b1;
                apb_addr  = CTRL_OFS;
                apb_wdata = CTRL_START_WR3;
                poll_d    = '0;
                if (apb_ack) state_d = apb_err ? S_ERR : S_POLL;
            end
            S_POLL: begin
                apb_req  = 1'b1;
                apb_wr   = 1'b0;
                apb_addr = STAT_OFS;
                if (apb_ack) begin
                    if (apb_err)                        state_d = S_ERR;
                    else if (!apb_rdata[0])             adv = 1'b1;
                    else if (poll_q == POLL_TO - 16'd1) state_d = S_ERR;
                    else                                poll_d = poll_q + 16'd1;
                end
            end
            // Occupies exactly N cycles; N=0 never gets here
            S_DELAY: begin
                if (dly_q == 24'd1) adv = 1'b1;
                else                dly_d = dly_q - 24'd1;
            end
            S_GPIO: begin
                apb_req   = 1'b1;
                apb_addr  = GPIO_OFS;
                apb_wdata = {31'b0, entry_q[0]};
                if (apb_ack) begin
                    if (apb_err) state_d = S_ERR;
                    else         adv = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            // Error and busy=0 become visible together on the way back to idle
            S_ERR: begin
                error_d = 1'b1;
                eidx_d  = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // The last table slot must hold END; never wrap to slot 0
        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_ERR;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign error    = error_q;
    assign err_idx  = eidx_q;
    assign tbl_addr = idx_q;

endmodule

// File: tb/tb_sccb_init_master.sv
// Directed bench for sccb_init_master: 4-entry table ROM, APB slave model
// with wait states, Busy poll counts and pslverr injection, and a transfer
// log used to compare bus activity against hand-built expectations.
module tb_sccb_init_master;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          go = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] err_idx, tbl_addr;
    logic [31:0]   tbl_data = '0;
    logic [31:0]   paddr, pwdata, prdata;
    logic          psel, penable, pwrite, pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sccb_init_master #(.TBL_AW(AW), .POLL_TO(16'd20)) dut (
        .clk(clk), .rstn(rstn), .go(go), .busy(busy), .done(done),
        .error(error), .err_idx(err_idx), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data),
        .M_APB_paddr(paddr), .M_APB_psel(psel), .M_APB_penable(penable),
        .M_APB_pwrite(pwrite), .M_APB_pwdata(pwdata),
        .M_APB_prdata(prdata), .M_APB_pready(pready), .M_APB_pslverr(pslverr)
    );

    // Table ROM: one cycle read latency
    logic [31:0] tbl [0:3];
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // APB slave model
    int waits = 0, wcnt = 0, busy_polls = 0, stat_cnt = 0, ctrl_cnt = 0;
    int err_ctrl_at = -1;
    assign pready  = psel && penable && (wcnt == waits);
    assign prdata  = (paddr == 32'h8 && stat_cnt < busy_polls) ? 32'h1 : 32'h0;
    assign pslverr = pready && pwrite && (paddr == 32'h4) && (ctrl_cnt == err_ctrl_at);

    always @(posedge clk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (pready && pwrite && paddr == 32'h4) begin
            ctrl_cnt <= ctrl_cnt + 1;
            stat_cnt <= 0;
        end else if (pready && !pwrite && paddr == 32'h8) begin
            stat_cnt <= stat_cnt + 1;
        end
    end

    // Cycle counter and transfer log
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] la[$], ld[$];
    bit          lw[$];
    int          lacc[$], lend[$], lsetup[$];
    int          acc_run = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!rstn) acc_run <= 0;
        else if (psel && !penable) lsetup.push_back(cyc);
        if (rstn && psel && penable) begin
            if (pready) begin
                la.push_back(paddr);
                ld.push_back(pwdata);
                lw.push_back(pwrite);
                lacc.push_back(acc_run + 1);
                lend.push_back(cyc);
                acc_run <= 0;
            end else begin
                acc_run <= acc_run + 1;
            end
        end
    end

    // Expected bus sequence for the two-write reference table (Busy for 3 polls)
    logic [31:0] ea[$], ed[$];
    bit          ew[$];

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input bit w);
        ea.push_back(a); ed.push_back(d); ew.push_back(w);
    endtask

    task automatic build_exp40();
        ea.delete(); ed.delete(); ew.delete();
        exp_push(32'hC, 32'h0032_0064, 1'b1);
        exp_push(32'h0, 32'h7830_0880, 1'b1);
        exp_push(32'h4, 32'h0000_0031, 1'b1);
        for (int i = 0; i < 4; i++) exp_push(32'h8, 32'h0, 1'b0);
        exp_push(32'h0, 32'h7831_0311, 1'b1);
        exp_push(32'h4, 32'h0000_0031, 1'b1);
        for (int i = 0; i < 4; i++) exp_push(32'h8, 32'h0, 1'b0);
    endtask

    task automatic load_tbl40();
        tbl[0] = 32'h4030_0880;
        tbl[1] = 32'h8000_0010;
        tbl[2] = 32'h4031_0311;
        tbl[3] = 32'h0000_0000;
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, done, error} !== 3'b000) begin
            n_fail++; $display("FAIL rst_flags got %b exp 000", {busy, done, error});
        end
        n_checks++;
        if ({err_idx, tbl_addr} !== '0) begin
            n_fail++; $display("FAIL rst_idx got %h exp 0", {err_idx, tbl_addr});
        end
        n_checks++;
        if ({psel, penable, pwrite} !== 3'b000) begin
            n_fail++; $display("FAIL rst_apb_ctl got %b exp 000", {psel, penable, pwrite});
        end
        n_checks++;
        if ({paddr, pwdata} !== 64'h0) begin
            n_fail++; $display("FAIL rst_apb_bus got %h exp 0", {paddr, pwdata});
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (lsetup.size() != 0 || psel !== 1'b0) begin
            n_fail++; $display("FAIL rst_quiet got %0d setups exp 0", lsetup.size());
        end
    endtask

    // Reference table; nwait wait states per transfer
    task automatic test_seq40(input int nwait, input string tag);
        int eb, sb, db;
        bit ok;
        load_tbl40();
        build_exp40();
        waits = nwait; busy_polls = 3; err_ctrl_at = -1;
        eb = la.size(); sb = lsetup.size(); db = done_cnt;
        pulse_go();
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_timeout got busy exp idle", tag); end
        n_checks++;
        if (la.size() - eb != ea.size()) begin
            n_fail++; $display("FAIL %s_count got %0d exp %0d", tag, la.size() - eb, ea.size());
        end else begin
            for (int i = 0; i < ea.size(); i++) begin
                n_checks++;
                if (la[eb+i] !== ea[i] || lw[eb+i] !== ew[i] ||
                    (ew[i] && ld[eb+i] !== ed[i])) begin
                    n_fail++;
                    $display("FAIL %s_xfer%0d got a=%h d=%h w=%b exp a=%h d=%h w=%b",
                             tag, i, la[eb+i], ld[eb+i], lw[eb+i], ea[i], ed[i], ew[i]);
                end
                n_checks++;
                if (lacc[eb+i] != nwait + 1) begin
                    n_fail++;
                    $display("FAIL %s_access%0d got %0d cycles exp %0d", tag, i, lacc[eb+i], nwait + 1);
                end
            end
            // Idle cycles after the last STAT read of entry 0: FETCH+DECODE of the
            // delay entry, 16 DELAY cycles, FETCH+DECODE of entry 2, request cycle
            n_checks++;
            if (lsetup[sb+7] - lend[eb+6] - 1 != 21) begin
                n_fail++;
                $display("FAIL %s_gap got %0d exp 21", tag, lsetup[sb+7] - lend[eb+6] - 1);
            end
        end
        n_checks++;
        if (done_cnt - db != 1) begin
            n_fail++; $display("FAIL %s_done got %0d exp 1", tag, done_cnt - db);
        end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL %s_error got %b exp 0", tag, error); end
    endtask

    task automatic test_poll_timeout();
        int eb, nstat;
        bit ok;
        tbl[0] = 32'h4012_3456; tbl[1] = 32'h0; tbl[2] = 32'h0; tbl[3] = 32'h0;
        waits = 0; busy_polls = 1000000; err_ctrl_at = -1;
        eb = la.size();
        pulse_go();
        wait_idle(ok);
        nstat = 0;
        for (int i = eb; i < la.size(); i++) if (la[i] == 32'h8) nstat++;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL to_timeout got busy exp idle"); end
        n_checks++;
        if (nstat != 20) begin n_fail++; $display("FAIL to_polls got %0d exp 20", nstat); end
        n_checks++;
        if (ld[eb+1] !== 32'h7812_3456) begin
            n_fail++; $display("FAIL to_data got %h exp 78123456", ld[eb+1]);
        end
        n_checks++;
        if (error !== 1'b1 || err_idx !== 2'd0) begin
            n_fail++; $display("FAIL to_err got err=%b idx=%0d exp err=1 idx=0", error, err_idx);
        end
    endtask

    task automatic test_slverr();
        bit ok;
        load_tbl40();
        waits = 0; busy_polls = 3; err_ctrl_at = ctrl_cnt + 1;
        pulse_go();
        wait_idle(ok);
        n_checks++;
        if (!ok || error !== 1'b1 || err_idx !== 2'd2) begin
            n_fail++; $display("FAIL slverr got ok=%b err=%b idx=%0d exp 1 1 2", ok, error, err_idx);
        end
        err_ctrl_at = -1;
        pulse_go();
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL slverr_clear got err=%b busy=%b exp 0 1", error, busy);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok || error !== 1'b0) begin
            n_fail++; $display("FAIL slverr_rerun got ok=%b err=%b exp 1 0", ok, error);
        end
    endtask

    task automatic test_reset_mid_poll();
        int eb, sb, db;
        bit hit, ok;
        tbl[0] = 32'h4000_0001; tbl[1] = 32'h0; tbl[2] = 32'h0; tbl[3] = 32'h0;
        waits = 0; busy_polls = 1000000; err_ctrl_at = -1;
        pulse_go();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (psel && penable && paddr == 32'h8) begin hit = 1'b1; break; end
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (!hit || psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst got hit=%b psel=%b pen=%b busy=%b exp 1 0 0 0", hit, psel, penable, busy);
        end
        @(negedge clk); rstn = 1'b1;
        sb = lsetup.size();
        repeat (5) @(negedge clk);
        n_checks++;
        if (lsetup.size() != sb) begin
            n_fail++; $display("FAIL midrst_quiet got %0d setups exp 0", lsetup.size() - sb);
        end
        busy_polls = 0;
        eb = la.size(); db = done_cnt;
        pulse_go();
        wait_idle(ok);
        n_checks++;
        if (!ok || la.size() - eb != 4 || la[eb] !== 32'hC || ld[eb] !== 32'h0032_0064) begin
            n_fail++; $display("FAIL midrst_restart got ok=%b n=%0d exp 1 4 starting at DIV", ok, la.size() - eb);
        end
        n_checks++;
        if (done_cnt - db != 1 || error !== 1'b0) begin
            n_fail++; $display("FAIL midrst_done got done=%0d err=%b exp 1 0", done_cnt - db, error);
        end
    endtask

    task automatic test_go_busy_no_end();
        int eb, ndiv;
        bit ok, was_busy;
        tbl[0] = 32'h8000_0004;
        tbl[1] = 32'hC000_0001;
        tbl[2] = 32'h8000_0000;
        tbl[3] = 32'h8000_0006;
        waits = 0; err_ctrl_at = -1;
        eb = la.size();
        pulse_go();
        repeat (3) @(negedge clk);
        was_busy = busy;
        go = 1'b1;
        @(negedge clk); go = 1'b0;
        wait_idle(ok);
        ndiv = 0;
        for (int i = eb; i < la.size(); i++) if (la[i] == 32'hC) ndiv++;
        n_checks++;
        if (!ok || !was_busy || ndiv != 1) begin
            n_fail++; $display("FAIL gobusy got ok=%b busy=%b div_writes=%0d exp 1 1 1", ok, was_busy, ndiv);
        end
        n_checks++;
        if (la.size() - eb != 2 || la[eb+1] !== 32'h10 || ld[eb+1] !== 32'h1) begin
            n_fail++; $display("FAIL gpio got n=%0d exp 2 with GPIO write of 1", la.size() - eb);
        end
        n_checks++;
        if (error !== 1'b1 || err_idx !== 2'd3 || tbl_addr !== 2'd3) begin
            n_fail++;
            $display("FAIL noend got err=%b idx=%0d addr=%0d exp 1 3 3", error, err_idx, tbl_addr);
        end
    endtask

    initial begin
        load_tbl40();
        test_reset();
        test_seq40(0, "seq0");
        test_seq40(2, "seq2");
        test_poll_timeout();
        test_slverr();
        test_reset_mid_poll();
        test_go_busy_no_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
